fight_frame_scheduler: RTL and testbench
========================================

# fight_frame_scheduler

Frame-synchronous controller that sequences what the VGA renderer draws each frame. It samples live game state (positions, health, hit events) once per frame, during vertical blank, so the pixel datapath never sees mid-frame changes. It times the per-player damage-flash windows and runs the KO → game-over sequence that drives the renderer's `finish[1:0]` input. It sits between game logic and `vga_bitchange`-style rendering, clocked by the pixel-domain `clk`.

## Interface
Parameters:
- `V_LATCH_LINE`, default 515: vCount line at which frame updates occur (first blank line after active video).
- `FLASH_FRAMES`, default 8: frames a damage flash lasts.
- `KO_FRAMES`, default 60: freeze frames between KO and game-over.
- `P1_X0`, default 200: reset x for p1. `P2_X0`, default 500: reset x for p2. `PY0`, default 266: reset y for both players.

Ports:
- `clk`  in  1  pixel clock.
- `rst`  in  1  synchronous, active-high reset.
- `hCount`, `vCount`  in  10 each  scan counters from the VGA timing block.
- `p1_x_in`, `p1_y_in`, `p2_x_in`, `p2_y_in`  in  10 each  live positions from game logic.
- `p1_health`, `p2_health`  in  4 each  live health.
- `p1_hit`, `p2_hit`  in  1  one-cycle pulse: that player took damage.
- `restart`  in  1  level/pulse; honoured only in OVER.
- `p1_x`, `p1_y`, `p2_x`, `p2_y`  out  10 each  frame-stable positions.
- `p1_flash`, `p2_flash`  out  1  player is in its damage-flash window.
- `finish`  out  2  bit0 = game over; bit1 = 1 if p1 lost.
- `frame_tick`  out  1  one-cycle pulse marking a frame update.

## Operation
- Update point: the clock edge at which `hCount==0 && vCount==V_LATCH_LINE`. All frame-level state changes occur only at that edge. `frame_tick` is registered high for exactly the following cycle.
- States: RUN, KO, OVER (2-bit encoding).
- RUN: at the update point, positions latch from the `*_in` inputs.
  - If either health is 0 at the update point, go to KO.
  - Load the KO counter with KO_FRAMES-1.
  - Capture loser: `loser_p1 = (p1_health==0 && p2_health!=0)`. A tie (both 0) records p2 as loser.
- KO: positions are frozen (not latched). The KO counter decrements each update point. At the update point where it reads 0, go to OVER.
- OVER: `finish = {loser_p1, 1}`. Positions stay frozen and both flashes are forced to 0. When `restart` is seen high (sticky until consumed), go to RUN at the next update point; that update point also latches positions and clears `finish` to 00.
- `finish` is 00 in RUN and KO.
- Flash timers (one per player): `pN_hit` sets a sticky pending flag at any cycle.
  - At an update point with pending set: load the counter with FLASH_FRAMES and clear pending.
  - Otherwise, at an update point with counter >0: decrement.
  - `pN_flash = (counter != 0)` and not in OVER.
  - A hit while flashing reloads the full window at the next update point. Hits arriving while in OVER are discarded.
- A hit pulse on the same edge as the update point counts for that update point.
- Counter widths: flash 4 bits; KO 7 bits. FLASH_FRAMES ≤ 15, KO_FRAMES ≤ 127, and both must be ≥ 1.

## Timing
- Reset values:
  - state RUN; `finish` 00; `frame_tick` 0; `p1_flash` and `p2_flash` 0; pending flags and counters 0.
  - `p1_x`=P1_X0, `p2_x`=P2_X0, `p1_y`=`p2_y`=PY0.
- All outputs are registered with no combinational path from inputs.
- Position latency: input to output 1 edge at the update point. Otherwise outputs hold.
- Flash: `pN_flash` rises on the update-point edge after the hit and stays high for exactly FLASH_FRAMES frames.
- KO entry to `finish[0]` high: KO_FRAMES update points.
- `rst` mid-sequence (KO or OVER) returns to reset values on the next edge.
- `restart` outside OVER is ignored and not remembered.

## Structure
- Shared package `fight_pkg`: state encoding (RUN/KO/OVER), VGA totals (800×525), V_LATCH_LINE, and the finish bit indices.
- One sub-module, `flash_timer`, instantiated twice. Ports: clk, rst, tick, hit, kill, flash.
- The top level holds the update-point detector, the state machine, the KO counter and the position registers.

## Test plan
- Reset, then run 2 frames with `p1_x_in=300` changing to 310 mid-frame: `p1_x` stays 200 until the first update point, then becomes 310. `frame_tick` pulses once per 525 lines.
- `p2_hit` pulse at line 100: `p2_flash` rises at the next update point and stays high for exactly 8 frame_ticks. A second hit in frame 4 extends the window to 8 frames after the reload.
- Hit on the same edge as the update point: flash starts at that edge (counter=8).
- `p1_health` drops to 0 in RUN: state is KO at the next update point and positions freeze. `finish` goes from 00 to 11 after 60 frames.
- Both healths reach 0 in the same frame: `finish` becomes 01 after KO. `restart` in OVER returns `finish` to 00 at the next update point. `restart` asserted in KO has no effect.
- `rst` asserted during KO frame 30: all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/fight_pkg.sv
// Shared definitions for the fight-game frame scheduler: controller states,
// VGA raster totals and the bit layout of the renderer's finish bus.
package fight_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_KO   = 2'd1,
    ST_OVER = 2'd2
  } fight_state_e;

  localparam int unsigned H_TOTAL              = 800;
  localparam int unsigned V_TOTAL              = 525;
  localparam int unsigned V_LATCH_LINE_DEFAULT = 515;

  localparam int unsigned FIN_OVER_BIT     = 0;
  localparam int unsigned FIN_LOSER_P1_BIT = 1;

endpackage

// File: rtl/fight_frame_scheduler_flash_timer.sv
// Per-player damage-flash window: hits are remembered until the next frame
// update, which (re)loads the full window; the window then counts down per frame.
module flash_timer #(
  parameter int unsigned FLASH_FRAMES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic hit,
  input  logic kill,
  output logic flash
);

  localparam logic [3:0] LOAD = 4'(FLASH_FRAMES);

  logic       pending_q;
  logic [3:0] cnt_q;
  logic       hit_ok;

  // While killed (game over) hits are dropped, not deferred.
  assign hit_ok = hit && !kill;

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= 1'b0;
      cnt_q     <= '0;
    end else if (tick) begin
      pending_q <= 1'b0;
      if (pending_q || hit_ok) begin
        cnt_q <= LOAD;
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - 4'd1;
      end
    end else if (hit_ok) begin
      pending_q <= 1'b1;
    end
  end

  assign flash = (cnt_q != '0) && !kill;

endmodule

// File: rtl/fight_frame_scheduler.sv
// Frame-synchronous game-state sampler: latches positions once per frame in
// vertical blank, times damage flashes and sequences KO -> game over.
module fight_frame_scheduler
  import fight_pkg::*;
#(
  parameter int unsigned V_LATCH_LINE = V_LATCH_LINE_DEFAULT,
  parameter int unsigned FLASH_FRAMES = 8,
  parameter int unsigned KO_FRAMES    = 60,
  parameter int unsigned P1_X0        = 200,
  parameter int unsigned P2_X0        = 500,
  parameter int unsigned PY0          = 266
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] hCount,
  input  logic [9:0] vCount,
  input  logic [9:0] p1_x_in,
  input  logic [9:0] p1_y_in,
  input  logic [9:0] p2_x_in,
  input  logic [9:0] p2_y_in,
  input  logic [3:0] p1_health,
  input  logic [3:0] p2_health,
  input  logic       p1_hit,
  input  logic       p2_hit,
  input  logic       restart,
  output logic [9:0] p1_x,
  output logic [9:0] p1_y,
  output logic [9:0] p2_x,
  output logic [9:0] p2_y,
  output logic       p1_flash,
  output logic       p2_flash,
  output logic [1:0] finish,
  output logic       frame_tick
);

  localparam logic [9:0] LATCH_V = 10'(V_LATCH_LINE);
  localparam logic [6:0] KO_LOAD = 7'(KO_FRAMES - 1);

  fight_state_e state_q, state_d;
  logic [6:0]   ko_cnt_q;
  logic         loser_p1_q;
  logic         restart_q;
  logic         upd;
  logic         latch_pos;
  logic         kill;

  assign upd  = (hCount == '0) && (vCount == LATCH_V);
  assign kill = (state_q == ST_OVER);

  always_comb begin
    state_d   = state_q;
    latch_pos = 1'b0;
    if (upd) begin
      case (state_q)
        ST_RUN: begin
          latch_pos = 1'b1;
          if (p1_health == '0 || p2_health == '0) state_d = ST_KO;
        end
        ST_KO: begin
          if (ko_cnt_q == '0) state_d = ST_OVER;
        end
        ST_OVER: begin
          // Restart also re-latches positions on the same update point.
          if (restart_q || restart) begin
            state_d   = ST_RUN;
            latch_pos = 1'b1;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      ko_cnt_q   <= '0;
      loser_p1_q <= 1'b0;
      restart_q  <= 1'b0;
      finish     <= '0;
      frame_tick <= 1'b0;
      p1_x       <= 10'(P1_X0);
      p1_y       <= 10'(PY0);
      p2_x       <= 10'(P2_X0);
      p2_y       <= 10'(PY0);
    end else begin
      state_q    <= state_d;
      frame_tick <= upd;

      if (latch_pos) begin
        p1_x <= p1_x_in;
        p1_y <= p1_y_in;
        p2_x <= p2_x_in;
        p2_y <= p2_y_in;
      end

      if (state_q == ST_RUN && state_d == ST_KO) begin
        ko_cnt_q   <= KO_LOAD;
        loser_p1_q <= (p1_health == '0) && (p2_health != '0);
      end else if (upd && state_q == ST_KO && ko_cnt_q != '0) begin
        ko_cnt_q <= ko_cnt_q - 7'd1;
      end

      // Restart requests are only remembered while already in OVER.
      if (state_q != ST_OVER || state_d == ST_RUN) begin
        restart_q <= 1'b0;
      end else if (restart) begin
        restart_q <= 1'b1;
      end

      if (state_q == ST_KO && state_d == ST_OVER) begin
        finish[FIN_OVER_BIT]     <= 1'b1;
        finish[FIN_LOSER_P1_BIT] <= loser_p1_q;
      end else if (state_q == ST_OVER && state_d == ST_RUN) begin
        finish <= '0;
      end
    end
  end

  flash_timer #(.FLASH_FRAMES(FLASH_FRAMES)) u_p1_flash (
    .clk   (clk),
    .rst   (rst),
    .tick  (upd),
    .hit   (p1_hit),
    .kill  (kill),
    .flash (p1_flash)
  );

  flash_timer #(.FLASH_FRAMES(FLASH_FRAMES)) u_p2_flash (
    .clk   (clk),
    .rst   (rst),
    .tick  (upd),
    .hit   (p2_hit),
    .kill  (kill),
    .flash (p2_flash)
  );

endmodule

// File: tb/tb_fight_frame_scheduler.sv
// Scoreboard bench for fight_frame_scheduler: frames are compressed by driving
// the scan counters directly; a frame-level model predicts each update.
module tb_fight_frame_scheduler;

  localparam int FLASH_N = 8;
  localparam int KO_N    = 60;
  localparam int VLINE   = 515;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] hCount = '0, vCount = '0;
  logic [9:0] p1_x_in = '0, p1_y_in = '0, p2_x_in = '0, p2_y_in = '0;
  logic [3:0] p1_health = 4'd10, p2_health = 4'd10;
  logic       p1_hit = 1'b0, p2_hit = 1'b0, restart = 1'b0;
  logic [9:0] p1_x, p1_y, p2_x, p2_y;
  logic       p1_flash, p2_flash, frame_tick;
  logic [1:0] finish;

  always #5 clk = ~clk;

  fight_frame_scheduler #(
    .V_LATCH_LINE(VLINE), .FLASH_FRAMES(FLASH_N), .KO_FRAMES(KO_N),
    .P1_X0(200), .P2_X0(500), .PY0(266)
  ) dut (
    .clk(clk), .rst(rst), .hCount(hCount), .vCount(vCount),
    .p1_x_in(p1_x_in), .p1_y_in(p1_y_in), .p2_x_in(p2_x_in), .p2_y_in(p2_y_in),
    .p1_health(p1_health), .p2_health(p2_health),
    .p1_hit(p1_hit), .p2_hit(p2_hit), .restart(restart),
    .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
    .p1_flash(p1_flash), .p2_flash(p2_flash),
    .finish(finish), .frame_tick(frame_tick)
  );

  typedef struct packed {
    logic [9:0] p1x, p1y, p2x, p2y;
    logic       f1, f2;
    logic [1:0] fin;
  } view_t;

  view_t q[$];
  view_t cur;
  int    n_checks = 0;
  int    n_pass   = 0;

  // Frame-level reference model
  bit         m_over;
  int         m_ko_left;       // update points remaining until game over; 0 = not in KO
  bit         m_loser_p1;
  bit         m_restart_req;
  int         m_flash_left[2]; // frames of flash remaining
  bit         m_pend[2];
  logic [9:0] m_pos[4];

  int         p_hit = 0, p_restart = 0;
  logic [3:0] h1_val = 4'd10, h2_val = 4'd10;

  function automatic view_t reset_view();
    view_t v;
    v.p1x = 10'd200; v.p1y = 10'd266; v.p2x = 10'd500; v.p2y = 10'd266;
    v.f1 = 1'b0; v.f2 = 1'b0; v.fin = 2'b00;
    return v;
  endfunction

  function automatic view_t model_view();
    view_t v;
    v.p1x = m_pos[0]; v.p1y = m_pos[1]; v.p2x = m_pos[2]; v.p2y = m_pos[3];
    v.f1  = (m_flash_left[0] > 0) && !m_over;
    v.f2  = (m_flash_left[1] > 0) && !m_over;
    v.fin = m_over ? {m_loser_p1, 1'b1} : 2'b00;
    return v;
  endfunction

  function automatic void model_reset();
    m_over = 0; m_ko_left = 0; m_loser_p1 = 0; m_restart_req = 0;
    for (int i = 0; i < 2; i++) begin m_flash_left[i] = 0; m_pend[i] = 0; end
    m_pos[0] = 10'd200; m_pos[1] = 10'd266; m_pos[2] = 10'd500; m_pos[3] = 10'd266;
  endfunction

  task automatic model_latch();
    m_pos[0] = p1_x_in; m_pos[1] = p1_y_in; m_pos[2] = p2_x_in; m_pos[3] = p2_y_in;
  endtask

  task automatic model_cycle(bit upd);
    bit h[2];
    h[0] = p1_hit; h[1] = p2_hit;
    if (!upd) begin
      for (int i = 0; i < 2; i++) if (h[i] && !m_over) m_pend[i] = 1;
      if (m_over && restart) m_restart_req = 1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_pend[i] || (h[i] && !m_over)) m_flash_left[i] = FLASH_N;
        else if (m_flash_left[i] > 0) m_flash_left[i]--;
        m_pend[i] = 0;
      end
      if (m_over) begin
        if (m_restart_req || restart) begin
          m_over = 0; m_restart_req = 0; model_latch();
        end
      end else if (m_ko_left > 0) begin
        m_ko_left--;
        if (m_ko_left == 0) m_over = 1;
      end else begin
        model_latch();
        if (p1_health == 0 || p2_health == 0) begin
          m_ko_left  = KO_N;
          m_loser_p1 = (p1_health == 0) && (p2_health != 0);
        end
      end
      q.push_back(model_view());
    end
  endtask

  function automatic bit chance(int pct);
    return int'($urandom_range(99)) < pct;
  endfunction

  task automatic pick_nonupd();
    case ($urandom_range(3))
      0: begin hCount = 10'd1; vCount = 10'(VLINE); end
      1: begin hCount = '0;    vCount = 10'(VLINE - 1); end
      2: begin hCount = '0;    vCount = 10'(VLINE + 1); end
      default: begin
        hCount = 10'($urandom_range(799));
        vCount = 10'($urandom_range(524));
        if (hCount == '0 && vCount == 10'(VLINE)) vCount = '0;
      end
    endcase
  endtask

  task automatic cycle(bit upd, bit h1, bit h2, bit rs);
    @(posedge clk); #1;
    if (upd) begin hCount = '0; vCount = 10'(VLINE); end
    else pick_nonupd();
    p1_x_in = 10'($urandom); p1_y_in = 10'($urandom);
    p2_x_in = 10'($urandom); p2_y_in = 10'($urandom);
    p1_health = h1_val; p2_health = h2_val;
    p1_hit = h1; p2_hit = h2; restart = rs;
    model_cycle(upd);
  endtask

  task automatic frame();
    int n;
    n = int'($urandom_range(9, 3));
    for (int i = 0; i < n - 1; i++) cycle(1'b0, chance(p_hit), chance(p_hit), chance(p_restart));
    cycle(1'b1, chance(p_hit), chance(p_hit), chance(p_restart));
  endtask

  task automatic do_reset(int n);
    @(posedge clk); #1;
    rst = 1'b1; p1_hit = 1'b0; p2_hit = 1'b0; restart = 1'b0;
    pick_nonupd();
    repeat (n) begin @(posedge clk); #1; end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic chk(string name, logic [44:0] act, logic [44:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Monitor: pops one expectation per frame_tick, otherwise outputs must hold.
  logic  rst_q = 1'b1;
  view_t got;
  always @(posedge clk) rst_q <= rst;

  always @(negedge clk) begin
    got.p1x = p1_x; got.p1y = p1_y; got.p2x = p2_x; got.p2y = p2_y;
    got.f1 = p1_flash; got.f2 = p2_flash; got.fin = finish;
    if (rst_q) begin
      cur = reset_view();
      chk("reset", {got, frame_tick}, {cur, 1'b0});
    end else if (frame_tick === 1'b1 && q.size() > 0) begin
      cur = q.pop_front();
      chk("update", {got, frame_tick}, {cur, 1'b1});
    end else begin
      chk("hold", {got, frame_tick}, {cur, 1'b0});
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    do_reset(3);

    // Mid-frame position changes, no hits
    repeat (3) frame();
    // Single p2 hit mid-frame, then a reload inside the window
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (4) frame();
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (10) frame();
    // Hit on the update-point edge itself
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (10) frame();
    // Random hits, random restarts ignored in RUN
    p_hit = 15; p_restart = 10;
    repeat (25) frame();

    // p1 KO; restarts during KO must be ignored
    h1_val = 4'd0;
    while (!m_over) frame();
    p_restart = 0;
    repeat (3) frame();
    h1_val = 4'd9;
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) frame();

    // Double KO: p2 recorded as loser; sticky restart
    h1_val = 4'd0; h2_val = 4'd0;
    while (!m_over) frame();
    repeat (2) frame();
    h1_val = 4'd7; h2_val = 4'd7;
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) frame();

    // p2 KO, restart on the update edge itself
    h2_val = 4'd0;
    while (!m_over) frame();
    h2_val = 4'd5;
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (3) frame();

    // Reset in the middle of a KO
    h1_val = 4'd0;
    frame();
    repeat (30) frame();
    h1_val = 4'd9;
    do_reset(2);
    repeat (5) frame();

    repeat (4) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("queue_drained", 45'(q.size()), 45'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
